// File: rtl/fdc_wb_master.sv
// Wishbone classic single-cycle initiator for the u765_wb FDC register slave.
// Each accepted CPU request becomes one bus read or write, ended by ACK or by a timeout.
module fdc_wb_master #(
  parameter int unsigned AW      = 3,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [DW-1:0] req_dat_i,
  output logic          rsp_done_o,
  output logic          rsp_err_o,
  output logic [DW-1:0] rsp_dat_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_d, cyc_d, we_d, done_d, err_d;
  logic [AW-1:0]   adr_d;
  logic [DW-1:0]   dat_d, rsp_dat_d;
  logic            accept_c, expire_c;

  assign accept_c = req_valid_i && req_ready_o;
  // Last cycle CYC may stay high without an ACK.
  assign expire_c = (cnt_q == CW'(TIMEOUT - 1));
  assign wb_stb_o = wb_cyc_o;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = BUS;
      BUS:     if (wb_ack_i || expire_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and timeout counter
  always_comb begin
    ready_d   = (state_d == IDLE);
    cyc_d     = wb_cyc_o;
    we_d      = wb_we_o;
    adr_d     = wb_adr_o;
    dat_d     = wb_dat_o;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rsp_dat_d = rsp_dat_o;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cyc_d = 1'b1;
          we_d  = req_we_i;
          adr_d = req_adr_i;
          dat_d = req_dat_i;
          cnt_d = '0;
        end
      end
      BUS: begin
        // ACK takes priority over a simultaneous expiry.
        if (wb_ack_i) begin
          cyc_d  = 1'b0;
          done_d = 1'b1;
          if (!wb_we_o) rsp_dat_d = wb_dat_i;
        end else if (expire_c) begin
          cyc_d  = 1'b0;
          done_d = 1'b1;
          err_d  = 1'b1;
          if (!wb_we_o) rsp_dat_d = {DW{1'b1}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cyc_d = 1'b0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_ready_o <= 1'b1;
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      rsp_done_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      cnt_q       <= '0;
    end else begin
      req_ready_o <= ready_d;
      wb_cyc_o    <= cyc_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      rsp_done_o  <= done_d;
      rsp_err_o   <= err_d;
      rsp_dat_o   <= rsp_dat_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
